sort_stimulus_gen: RTL
======================

// Module: sort_stimulus_gen
// PURPOSE
//  Initiator side of the sorter load/trigger/done handshake. On a start pulse it
//  generates DATA_W-bit pseudo-random numbers from an 8-bit LFSR and loads four of them
//  into the sorter. It then raises sort_trigger and holds it until sorting_done.
//  It captures the sorter's four outputs, checks their order and releases the handshake.
//  Sits between the button/debounce logic and the sorter; its results feed the display path.
// PARAMETERS
//  DATA_W         4      width of each number (LFSR low bits used)
//  LFSR_SEED      8'hA5  LFSR value after reset; must be nonzero
//  TIMEOUT_CYCLES 1024   max cycles to wait for sorting_done (SORT_TIMEOUT_EN only)
// PORTS
//  clk           in   1       system clock, all logic on rising edge
//  rst           in   1       asynchronous, active-high reset
//  start         in   1       one-cycle request; ignored unless state==IDLE
//  sorting_done  in   1       sorter done flag
//  sorted_in_0..3 in  DATA_W  sorter results, valid while sorting_done=1
//  load_num      out  1       load strobe to sorter, one cycle per number
//  load_idx      out  2       slot index of current load (0..3)
//  random_num    out  DATA_W  number presented with load_num
//  sort_trigger  out  1       sort request level
//  result_0..3   out  DATA_W  captured sorted values
//  result_valid  out  1       one-cycle pulse: new results available
//  result_sorted out  1       1 if result_0<=result_1<=result_2<=result_3 (unsigned)
//  busy          out  1       1 in any state other than IDLE
//  timeout_err   out  1       sticky sorter timeout flag
// BEHAVIOUR
//  Reset: all outputs 0, lfsr=LFSR_SEED, state=IDLE. Asserting rst mid-op aborts at once.
//  All outputs are registered.
//  LFSR: fb = l[7]^l[5]^l[4]^l[3]; l <= {l[6:0],fb}. random_num = l[DATA_W-1:0].
//   The LFSR advances once per load cycle, after its value is presented, and holds otherwise.
//  IDLE: start=1 -> LOAD, idx=0, timeout_err cleared.
//  LOAD: 4 consecutive cycles with load_num=1, load_idx=0,1,2,3 and random_num=current lfsr
//   low bits. After idx 3 -> TRIG. load_num=0 in every other state.
//  TRIG: sort_trigger=1. Sorter consumes trigger on first high cycle; when sorting_done=1,
//   latch sorted_in_0..3 into result_0..3 and compute result_sorted, -> REL.
//   If sorting_done is already 1 on TRIG's first cycle, capture happens the same cycle.
//  REL: sort_trigger=0; wait for sorting_done=0, then pulse result_valid for 1 cycle and
//   return to IDLE. The sorter is back in its wait state before any new load.
//  Latency: start->first load_num 1 cycle; loads occupy 4 cycles; trigger rises the cycle
//   after load_idx=3.
//  result_* hold until the next capture; they are not cleared by start.
//  start while busy: dropped, no queueing. start and sorting_done together in IDLE: start wins.
// CONFIGURATION
//  SORT_TIMEOUT_EN defined: a cycle counter runs in TRIG. If TIMEOUT_CYCLES elapse without
//   sorting_done: sort_trigger drops, timeout_err=1 (sticky until next accepted start),
//   no capture, no result_valid, -> IDLE.
//  SORT_TIMEOUT_EN undefined: no counter; TRIG waits indefinitely; timeout_err tied 0.
// TESTING
//  1 Reset, start pulse -> load_num high 4 cycles, load_idx 0..3, random_num 5,A,5,A (seed A5).
//  2 Sorter model returns 1,3,7,C with done after 5 cycles -> result_0..3=1,3,7,C,
//    result_sorted=1, result_valid single pulse after done falls.
//  3 Sorter model returns 9,2,2,4 -> result_sorted=0, result_valid still pulses.
//  4 start pulsed during LOAD and TRIG -> ignored; exactly one load burst and one result_valid.
//  5 rst asserted mid-LOAD (idx=2) -> outputs 0 asynchronously; next start reloads 5,A,5,A.
//  6 SORT_TIMEOUT_EN, TIMEOUT_CYCLES=16, done never rises -> trigger drops after 16 cycles,
//    timeout_err=1, no result_valid; next start clears timeout_err.

Source files
------------

// File: rtl/sort_stimulus_gen.sv
// Sorter initiator: loads four LFSR-generated numbers, triggers the sort, and captures and checks the results.
// Optional sorter timeout is compiled in with `define SORT_TIMEOUT_EN.
module sort_stimulus_gen #(
  parameter int unsigned DATA_W         = 4,
  parameter logic [7:0]  LFSR_SEED      = 8'hA5,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              sorting_done,
  input  logic [DATA_W-1:0] sorted_in_0,
  input  logic [DATA_W-1:0] sorted_in_1,
  input  logic [DATA_W-1:0] sorted_in_2,
  input  logic [DATA_W-1:0] sorted_in_3,
  output logic              load_num,
  output logic [1:0]        load_idx,
  output logic [DATA_W-1:0] random_num,
  output logic              sort_trigger,
  output logic [DATA_W-1:0] result_0,
  output logic [DATA_W-1:0] result_1,
  output logic [DATA_W-1:0] result_2,
  output logic [DATA_W-1:0] result_3,
  output logic              result_valid,
  output logic              result_sorted,
  output logic              busy,
  output logic              timeout_err
);

  if (LFSR_SEED == 8'h00) begin : g_seed_check
    $error("LFSR_SEED must be nonzero");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_tmo_check
    $error("TIMEOUT_CYCLES must be at least 1");
  end
  if (DATA_W > 8) begin : g_width_check
    $error("DATA_W must not exceed the 8-bit LFSR width");
  end

  typedef enum logic [1:0] {IDLE, LOAD, TRIG, REL} state_t;

  state_t     state;
  logic [7:0] lfsr;
  logic [7:0] lfsr_next;
  logic       in_order;
  logic       tmo_hit;

  always_comb begin
    lfsr_next = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    in_order  = (sorted_in_0 <= sorted_in_1) && (sorted_in_1 <= sorted_in_2) &&
                (sorted_in_2 <= sorted_in_3);
  end

`ifdef SORT_TIMEOUT_EN
  localparam int unsigned TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [TMO_W-1:0] tmo_cnt;

  // Counter is zero on TRIG's first cycle, so the limit is hit after exactly TIMEOUT_CYCLES cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt <= '0;
    end else if (state != TRIG) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  always_comb tmo_hit = (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
`else
  always_comb tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      lfsr          <= LFSR_SEED;
      load_num      <= 1'b0;
      load_idx      <= '0;
      random_num    <= '0;
      sort_trigger  <= 1'b0;
      result_0      <= '0;
      result_1      <= '0;
      result_2      <= '0;
      result_3      <= '0;
      result_valid  <= 1'b0;
      result_sorted <= 1'b0;
      busy          <= 1'b0;
      timeout_err   <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state       <= LOAD;
            busy        <= 1'b1;
            timeout_err <= 1'b0;
            load_num    <= 1'b1;
            load_idx    <= '0;
            random_num  <= lfsr[DATA_W-1:0];
            lfsr        <= lfsr_next;
          end
        end
        // Outputs are registered, so each edge presents the next slot and advances the LFSR.
        LOAD: begin
          if (load_idx == 2'd3) begin
            state        <= TRIG;
            load_num     <= 1'b0;
            sort_trigger <= 1'b1;
          end else begin
            load_idx   <= load_idx + 2'd1;
            random_num <= lfsr[DATA_W-1:0];
            lfsr       <= lfsr_next;
          end
        end
        TRIG: begin
          if (sorting_done) begin
            state         <= REL;
            sort_trigger  <= 1'b0;
            result_0      <= sorted_in_0;
            result_1      <= sorted_in_1;
            result_2      <= sorted_in_2;
            result_3      <= sorted_in_3;
            result_sorted <= in_order;
          end else if (tmo_hit) begin
            state        <= IDLE;
            sort_trigger <= 1'b0;
            busy         <= 1'b0;
            timeout_err  <= 1'b1;
          end
        end
        REL: begin
          if (!sorting_done) begin
            state        <= IDLE;
            busy         <= 1'b0;
            result_valid <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
